cook_timer: RTL and testbench
=============================

Name: cook_timer

Overview:
- Countdown cook timer for the microwave controller; the counterpart to the magnetron controller. It consumes the magnetron-on signal and produces the `timer_done` input that the magnetron controller uses to reset its latch.
- Holds an MM:SS time in four BCD digits. Digits are loaded from the keypad while the magnetron is off. The time decrements once per second while the magnetron is on.
- Drives `timer_done` and the display digits.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per one-second tick; must be >= 2.
- BEEP_TICKS, 3, seconds the beeper stays high after countdown expiry. Used only with COOK_TIMER_BEEP_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mag_on  in  1  magnetron on (Q of the magnetron controller); enables counting.
- clearn  in  1  active-low clear of the time; sampled synchronously.
- key_valid  in  1  one-cycle strobe; `key_digit` is valid.
- key_digit  in  4  BCD digit 0-9; values 10-15 are ignored.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits.
- timer_done  out  1  high when the time is 00:00.
- running  out  1  high in state RUN.
- beep  out  1  expiry beeper; tied 0 without COOK_TIMER_BEEP_EN.

Behaviour:
- Reset values:
  - All digits 0; `timer_done` = 1; `running` = 0; `beep` = 0.
  - State ZERO; prescaler = 0.
- `timer_done` is combinational from the digit registers (all four zero). It is valid in the same cycle the registers reach zero.
- States and transitions:
  - ZERO (time 00:00):
    - valid nonzero key -> SET.
    - `mag_on` is ignored; no decrement.
  - SET (time nonzero, not counting):
    - `mag_on` = 1 -> RUN.
    - `clearn` = 0 -> ZERO.
  - RUN:
    - `mag_on` = 0 -> SET (pause; time is held).
    - Decrement reaching 00:00 -> ZERO.
    - `clearn` = 0 -> ZERO.
- Digit entry:
  - Accepted only when `mag_on` = 0, `clearn` = 1, `key_valid` = 1 and `key_digit` <= 9.
  - Shift left: min_tens <= min_ones <= sec_tens <= sec_ones <= key_digit. The old min_tens is discarded.
  - An entered zero digit with a zero result stays in ZERO.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and is forced to 0 otherwise, so each resume waits a full second.
  - Tick fires on the cycle the count equals TICK_DIV-1.
  - The decrement is visible on the next cycle.
- Decrement (BCD):
  - sec_ones borrows from sec_tens.
  - When seconds are 00, seconds become 59 and minutes decrement with BCD borrow.
  - Entered seconds above 59 (e.g. 1:75) are legal and count down normally from 75.
- Priority, highest first: `reset`, then `clearn` = 0, then decrement tick, then key entry.
  - Key entry cannot coincide with a tick, because entry requires `mag_on` = 0.
- `clearn` held low: digits stay 0 and keys are ignored.
- `reset` mid-count: everything returns to its reset value on the next edge.

Optional Feature:
- Macro: COOK_TIMER_BEEP_EN.
- Defined:
  - On a decrement that reaches 00:00, `beep` goes high on the same cycle as `timer_done`.
  - `beep` stays high for BEEP_TICKS ticks. During the beep the prescaler runs regardless of state.
  - `beep` is cancelled immediately by `clearn` = 0, by an accepted key, or by `reset`.
  - A clear that reaches 00:00 never starts a beep.
- Undefined:
  - `beep` = 0 constant; no beep counter is synthesized.
  - The prescaler runs only in RUN.

Decomposition:
- Package `microwave_pkg`:
  - State enum (ZERO, SET, RUN).
  - BCD digit typedef (4 bits).
  - Constants BCD_MAX = 9 and SEC_TENS_WRAP = 5.
- Sub-module `tick_gen`:
  - Parameterized TICK_DIV prescaler with inputs `enable` and synchronous clear.
  - One-cycle `tick` output.

Test Plan (TICK_DIV = 4 in simulation):
- Keys 1,3,0 with `mag_on` = 0 -> digits 0,1,3,0 (01:30), `timer_done` = 0, state SET.
- With 00:02 loaded, `mag_on` = 1 -> 00:01 at cycle 4 and 00:00 at cycle 8 after `mag_on` rises. At cycle 8 `timer_done` = 1, `running` = 0, and `beep` = 1 for 12 cycles if COOK_TIMER_BEEP_EN is defined.
- Time 01:00 with one tick -> 00:59. Time 10:00 with one tick -> 09:59.
- Pause: `mag_on` low for 10 cycles mid-second -> time frozen. After resume, the next decrement comes exactly 4 cycles later.
- `clearn` = 0 in the same cycle as a tick at 00:05 -> 00:00, `timer_done` = 1, `beep` stays 0.
- Keys while `mag_on` = 1, and key_digit = 12 -> digits unchanged. `reset` pulse mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// ---------------------------------------------------------------------------
// microwave_pkg: shared types, constants and the BCD countdown helper for the
// microwave cook timer.
//   state_e   : timer state (ZERO / SET / RUN)
//   bcd_t     : one BCD display digit
//   mmss_t    : MM:SS time as four BCD digits, min_tens in the MSBs
//   bcd_dec() : one-second BCD decrement of a nonzero MM:SS value
// ---------------------------------------------------------------------------
package microwave_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        SET  = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    localparam bcd_t BCD_MAX       = 4'd9;
    localparam bcd_t SEC_TENS_WRAP = 4'd5;

    // Only ever applied to a nonzero time, so the minutes borrow cannot
    // underflow. Seconds above 59 (e.g. 1:75) simply count down from there.
    function automatic mmss_t bcd_dec(mmss_t t);
        mmss_t r;
        r = t;
        if (t.sec_ones != '0) begin
            r.sec_ones = t.sec_ones - 1'b1;
        end else begin
            r.sec_ones = BCD_MAX;
            if (t.sec_tens != '0) begin
                r.sec_tens = t.sec_tens - 1'b1;
            end else begin
                r.sec_tens = SEC_TENS_WRAP;
                if (t.min_ones != '0) begin
                    r.min_ones = t.min_ones - 1'b1;
                end else begin
                    r.min_ones = BCD_MAX;
                    r.min_tens = t.min_tens - 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cook_timer_if.sv
// ---------------------------------------------------------------------------
// cook_timer_if: keypad / magnetron / display signals of the cook timer.
//   mag_on, clearn, key_valid, key_digit : controller side -> timer
//   min_tens..sec_ones, timer_done, running, beep : timer -> controller side
// Modports: master (controller / testbench), slave (cook_timer).
// ---------------------------------------------------------------------------
interface cook_timer_if;
    import microwave_pkg::*;

    logic mag_on;
    logic clearn;
    logic key_valid;
    bcd_t key_digit;
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic timer_done;
    logic running;
    logic beep;

    modport master (
        output mag_on, clearn, key_valid, key_digit,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done, running, beep
    );

    modport slave (
        input  mag_on, clearn, key_valid, key_digit,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done, running, beep
    );

endinterface

// File: rtl/cook_timer_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen: one-second prescaler. Counts 0..TICK_DIV-1 while enabled and
// pulses tick for one cycle when the count sits at TICK_DIV-1.
//   clk    : system clock
//   clear  : synchronous clear of the count (wins over enable)
//   enable : advance the count
//   tick   : one-cycle pulse, once per TICK_DIV enabled cycles
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/cook_timer.sv
// ---------------------------------------------------------------------------
// cook_timer: MM:SS countdown timer for the microwave controller.
// Digits shift in from the keypad while the magnetron is off; the time counts
// down once per second while the magnetron is on. timer_done (time == 00:00)
// feeds the magnetron controller's latch reset.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : cook_timer_if.slave (mag_on, clearn, key_valid, key_digit in;
//                display digits, timer_done, running, beep out)
// Optional feature macro: COOK_TIMER_BEEP_EN (expiry beeper for BEEP_TICKS
// seconds; without it beep is constant 0 and no beep counter exists).
// ---------------------------------------------------------------------------
module cook_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000
`ifdef COOK_TIMER_BEEP_EN
    ,
    parameter int BEEP_TICKS = 3
`endif
) (
    input  logic         clk,
    input  logic         reset,
    cook_timer_if.slave  bus
);

    state_e r_state;
    mmss_t  r_time;

    logic   w_tick;
    logic   w_presc_en;
    logic   w_tick_run;
    logic   w_key_ok;
    logic   w_beep;
    mmss_t  w_dec;
    mmss_t  w_shift;

    assign w_dec      = bcd_dec(r_time);
    assign w_shift    = {r_time.min_ones, r_time.sec_tens, r_time.sec_ones, bus.key_digit};
    assign w_tick_run = (r_state == RUN) && w_tick;

    // A tick can only land in RUN; if mag_on drops on that very cycle the
    // decrement still wins and the key is dropped.
    assign w_key_ok = !bus.mag_on && bus.clearn && bus.key_valid &&
                      (bus.key_digit <= BCD_MAX) && !w_tick_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ZERO;
            r_time  <= '0;
        end else if (!bus.clearn) begin
            r_state <= ZERO;
            r_time  <= '0;
        end else if (w_tick_run) begin
            r_time <= w_dec;
            if (w_dec == '0)     r_state <= ZERO;
            else if (!bus.mag_on) r_state <= SET;
        end else if (w_key_ok) begin
            // Shifting can also discard the only nonzero digit (10:00 + 0).
            r_time  <= w_shift;
            r_state <= (w_shift == '0) ? ZERO : SET;
        end else begin
            case (r_state)
                SET:     if (bus.mag_on)  r_state <= RUN;
                RUN:     if (!bus.mag_on) r_state <= SET;
                default: r_state <= r_state;
            endcase
        end
    end

`ifdef COOK_TIMER_BEEP_EN
    localparam int BW = $clog2(BEEP_TICKS + 1);

    logic [BW-1:0] r_beep_cnt;

    // Counts remaining beep seconds; only a decrement to 00:00 arms it.
    always_ff @(posedge clk) begin
        if (reset || !bus.clearn || w_key_ok) begin
            r_beep_cnt <= '0;
        end else if (w_tick_run && (w_dec == '0)) begin
            r_beep_cnt <= BW'(BEEP_TICKS);
        end else if (w_tick && (r_beep_cnt != '0)) begin
            r_beep_cnt <= r_beep_cnt - 1'b1;
        end
    end

    assign w_beep     = (r_beep_cnt != '0);
    assign w_presc_en = (r_state == RUN) || w_beep;
`else
    assign w_beep     = 1'b0;
    assign w_presc_en = (r_state == RUN);
`endif

    // Clearing whenever disabled makes every resume wait a full second.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .clear  (reset || !w_presc_en),
        .enable (w_presc_en),
        .tick   (w_tick)
    );

    assign bus.min_tens   = r_time.min_tens;
    assign bus.min_ones   = r_time.min_ones;
    assign bus.sec_tens   = r_time.sec_tens;
    assign bus.sec_ones   = r_time.sec_ones;
    assign bus.timer_done = (r_time == '0);
    assign bus.running    = (r_state == RUN);
    assign bus.beep       = w_beep;

endmodule

// File: tb/tb_cook_timer.sv
// ---------------------------------------------------------------------------
// tb_cook_timer: scoreboard bench for cook_timer (TICK_DIV = 4).
// The driver applies one input vector per cycle, advances a reference model
// kept as minutes/seconds arithmetic plus a running flag, and queues the
// expected outputs; an independent monitor pops and compares every cycle.
// ---------------------------------------------------------------------------
module tb_cook_timer;

    localparam int TICK_DIV = 4;
`ifdef COOK_TIMER_BEEP_EN
    localparam int BEEP_TICKS = 3;
`endif

    typedef struct {
        logic [15:0] digits;
        logic        done;
        logic        run;
        logic        beep;
    } exp_t;

    logic clk;
    logic reset;
    cook_timer_if bus_if ();

    cook_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: time digits, running flag, second phase, beep seconds.
    int m_d[4];
    bit m_run;
    int m_phase;
    int m_beep;

    function automatic bit m_zero();
        return (m_d[0] == 0) && (m_d[1] == 0) && (m_d[2] == 0) && (m_d[3] == 0);
    endfunction

    function automatic void model(bit rst, bit mag, bit clr, bit kv, int kd);
        bit en, tick;
        int mins, secs;
        int nd[4];
        if (rst) begin
            m_d = '{0, 0, 0, 0};
            m_run = 0; m_phase = 0; m_beep = 0;
            return;
        end
        en      = m_run || (m_beep > 0);
        tick    = en && (m_phase == TICK_DIV - 1);
        m_phase = en ? (m_phase + 1) % TICK_DIV : 0;
        if (!clr) begin
            m_d = '{0, 0, 0, 0};
            m_run = 0; m_beep = 0;
        end else if (m_run && tick) begin
            mins = m_d[0] * 10 + m_d[1];
            secs = m_d[2] * 10 + m_d[3];
            if (secs > 0) secs--;
            else begin secs = 59; mins--; end
            m_d = '{mins / 10, mins % 10, secs / 10, secs % 10};
            if (m_zero()) begin
                m_run = 0;
`ifdef COOK_TIMER_BEEP_EN
                m_beep = BEEP_TICKS;
`endif
            end else begin
                m_run = mag;
            end
        end else if (!mag && kv && kd <= 9) begin
            nd = '{m_d[1], m_d[2], m_d[3], kd};
            m_d = nd;
            m_run = 0; m_beep = 0;
        end else begin
            if (tick && m_beep > 0) m_beep--;
            if (m_run) m_run = mag;
            else if (mag && !m_zero()) m_run = 1;
        end
    endfunction

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_digits();
        return {bus_if.min_tens, bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones};
    endfunction

    // Apply one input vector for the next edge, queue the model's outcome,
    // and return 1 time unit after that edge.
    task automatic step(bit rst, bit mag, bit clr, bit kv, int kd);
        exp_t e;
        reset            = rst;
        bus_if.mag_on    = mag;
        bus_if.clearn    = clr;
        bus_if.key_valid = kv;
        bus_if.key_digit = 4'(kd);
        model(rst, mag, clr, kv, kd);
        e.digits = {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3])};
        e.done   = (e.digits == 16'h0000);
        e.run    = m_run;
        e.beep   = (m_beep > 0);
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic key(int d);   step(0, 0, 1, 1, d); endtask
    task automatic clr();        step(0, 0, 0, 0, 0); endtask
    task automatic run(int n);   for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0); endtask

    task automatic chk_all(string nm, logic [15:0] dg, logic dn, logic rn, logic bp);
        check({nm, ".digits"}, dut_digits(), dg);
        check({nm, ".done"}, 16'(bus_if.timer_done), 16'(dn));
        check({nm, ".running"}, 16'(bus_if.running), 16'(rn));
        check({nm, ".beep"}, 16'(bus_if.beep), 16'(bp));
    endtask

    // Monitor: 2 units after each edge, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb.digits", dut_digits(), e.digits);
                check("sb.done", 16'(bus_if.timer_done), 16'(e.done));
                check("sb.running", 16'(bus_if.running), 16'(e.run));
                check("sb.beep", 16'(bus_if.beep), 16'(e.beep));
            end
        end
    end

    initial begin
        bit mag;
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk_all("reset", 16'h0000, 1, 0, 0);

        // Entry 1,3,0 -> 01:30
        key(1); key(3); key(0);
        chk_all("entry", 16'h0130, 0, 0, 0);

        // 00:02 countdown
        clr(); key(2);
        for (int i = 1; i <= 9; i++) begin
            step(0, 1, 1, 0, 0);
            if (i == 4) check("cd.hold", dut_digits(), 16'h0002);
            if (i == 5) check("cd.first", dut_digits(), 16'h0001);
            if (i == 8) check("cd.mid", dut_digits(), 16'h0001);
        end
`ifdef COOK_TIMER_BEEP_EN
        chk_all("cd.expire", 16'h0000, 1, 0, 1);
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 1, 0, 0);
            check("beep.high", 16'(bus_if.beep), 16'h1);
        end
        step(0, 0, 1, 0, 0);
        check("beep.end", 16'(bus_if.beep), 16'h0);
`else
        chk_all("cd.expire", 16'h0000, 1, 0, 0);
`endif

        // Minute borrow
        clr(); key(1); key(0); key(0); run(5);
        check("borrow.1m", dut_digits(), 16'h0059);
        step(0, 0, 1, 0, 0);
        clr(); key(1); key(0); key(0); key(0); run(5);
        chk_all("borrow.10m", 16'h0959, 0, 1, 0);

        // Pause mid-second, then resume
        run(2);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
        chk_all("pause", 16'h0959, 0, 0, 0);
        run(4);
        check("resume.hold", dut_digits(), 16'h0959);
        run(1);
        check("resume.tick", dut_digits(), 16'h0958);

        // Clear coinciding with a tick
        step(0, 0, 1, 0, 0);
        clr(); key(5); run(4);
        step(0, 1, 0, 0, 0);
        chk_all("clr.tick", 16'h0000, 1, 0, 0);

        // Ignored keys, then reset mid-run
        key(1); key(2); key(3); key(4);
        step(0, 1, 1, 1, 7);
        chk_all("key.mag", 16'h1234, 0, 1, 0);
        step(0, 0, 1, 1, 12);
        chk_all("key.bad", 16'h1234, 0, 0, 0);
        run(2);
        step(1, 1, 1, 0, 0);
        chk_all("reset.run", 16'h0000, 1, 0, 0);

        // Randomized traffic against the model
        mag = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) mag = !mag;
            step($urandom_range(0, 299) == 0, mag, $urandom_range(0, 59) != 0,
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
        end

        step(0, 0, 1, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
